// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the pipelined barrel shifter.
//   - MODE_* : 3-bit shift mode encodings (values above MODE_ROL are reserved)
//   - is_reserved() : true for an encoding that has no defined operation
//   - log2_const()  : ceiling log2, usable in parameter expressions
package shifter_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    function automatic logic is_reserved(input logic [2:0] mode);
        return (mode > MODE_ROL);
    endfunction

    function automatic int log2_const(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_level.sv
// shift_level: one combinational barrel level that shifts or rotates by a
// fixed distance DIST when enabled.
// Ports:
//   din   in  WIDTH  data entering the level
//   en    in  1      apply this level's shift (else pass-through)
//   mode  in  3      shift mode (shifter_pkg MODE_*)
//   fill  in  1      bit shifted in from the top for right shifts
//   dout  out WIDTH  data leaving the level
//   carry out 1      last bit moved out by this level (0 when not enabled)
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] dout,
    output logic             carry
);

    always_comb begin
        dout  = din;
        carry = 1'b0;
        if (en) begin
            case (mode)
                MODE_SLL: begin
                    dout  = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
                    carry = din[WIDTH-DIST];
                end
                MODE_SRL, MODE_SRA: begin
                    dout  = {{DIST{fill}}, din[WIDTH-1:DIST]};
                    carry = din[DIST-1];
                end
                MODE_ROR: begin
                    dout  = {din[DIST-1:0], din[WIDTH-1:DIST]};
                    carry = din[DIST-1];        // becomes the result MSB
                end
                MODE_ROL: begin
                    dout  = {din[WIDTH-DIST-1:0], din[WIDTH-1:WIDTH-DIST]};
                    carry = din[WIDTH-DIST];    // becomes the result LSB
                end
                default: begin
                    dout  = din;
                    carry = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL) with a
// valid/ready handshake, backpressure, an opaque tag and a synchronous flush.
// LEVELS = log2(WIDTH) barrel levels; a register stage follows every
// REG_EVERY levels, so LAT = LEVELS/REG_EVERY. The last stage drives outputs.
// Optional feature macro: SHIFTER_CARRY_EN adds out_carry (last bit shifted
// or rotated out), pipelined alongside the data.
// Ports:
//   clk, rst (async, active-high), flush (sync squash of in-flight ops)
//   in_valid/in_ready, in_data, in_amt, in_mode, in_tag : operation input
//   out_valid/out_ready, out_data, out_tag, out_illegal : result output
//   out_carry (SHIFTER_CARRY_EN only)
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int  WIDTH     = 16,
    parameter int  REG_EVERY = 2,
    parameter int  TAG_W     = 4,
    localparam int LEVELS    = log2_const(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_amt,
    input  logic [2:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
`ifdef SHIFTER_CARRY_EN
    ,
    output logic              out_carry
`endif
);

    localparam int LAT = LEVELS / REG_EVERY;

    logic stall;

    // Stage registers
    logic              vld_p  [LAT];
    logic [WIDTH-1:0]  data_p [LAT];
    logic [LEVELS-1:0] amt_p  [LAT];
    logic [2:0]        mode_p [LAT];
    logic [TAG_W-1:0]  tag_p  [LAT];
    logic              ill_p  [LAT];

    // Inputs seen by each stage's combinational levels, and their result
    logic              st_vld  [LAT];
    logic [WIDTH-1:0]  st_data [LAT];
    logic [LEVELS-1:0] st_amt  [LAT];
    logic [2:0]        st_mode [LAT];
    logic [TAG_W-1:0]  st_tag  [LAT];
    logic              st_ill  [LAT];
    logic [WIDTH-1:0]  sh_data [LAT];

`ifdef SHIFTER_CARRY_EN
    logic cy_p  [LAT];
    logic st_cy [LAT];
    logic sh_cy [LAT];
`endif

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !flush;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        if (s == 0) begin : g_src
            assign st_vld[s]  = in_valid;
            assign st_data[s] = in_data;
            assign st_amt[s]  = in_amt;
            assign st_mode[s] = in_mode;
            assign st_tag[s]  = in_tag;
            assign st_ill[s]  = is_reserved(in_mode);
`ifdef SHIFTER_CARRY_EN
            assign st_cy[s]   = 1'b0;
`endif
        end else begin : g_src
            assign st_vld[s]  = vld_p[s-1];
            assign st_data[s] = data_p[s-1];
            assign st_amt[s]  = amt_p[s-1];
            assign st_mode[s] = mode_p[s-1];
            assign st_tag[s]  = tag_p[s-1];
            assign st_ill[s]  = ill_p[s-1];
`ifdef SHIFTER_CARRY_EN
            assign st_cy[s]   = cy_p[s-1];
`endif
        end

        logic [WIDTH-1:0] lvl_d [REG_EVERY+1];
        assign lvl_d[0] = st_data[s];
`ifdef SHIFTER_CARRY_EN
        // Carry is taken from the highest enabled level; disabled levels
        // forward whatever the lower levels produced.
        logic lvl_cy [REG_EVERY+1];
        assign lvl_cy[0] = st_cy[s];
`endif

        for (genvar j = 0; j < REG_EVERY; j++) begin : g_lvl
            localparam int K = s * REG_EVERY + j;
            logic lvl_en;
            logic lvl_fill;
            logic lvl_c;

            // Reserved modes disable every level so the operand passes through.
            assign lvl_en   = st_amt[s][K] && !st_ill[s];
            // Earlier SRA levels keep the MSB equal to the original sign bit.
            assign lvl_fill = (st_mode[s] == MODE_SRA) && lvl_d[j][WIDTH-1];

            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << K)
            ) u_level (
                .din   (lvl_d[j]),
                .en    (lvl_en),
                .mode  (st_mode[s]),
                .fill  (lvl_fill),
                .dout  (lvl_d[j+1]),
                .carry (lvl_c)
            );

`ifdef SHIFTER_CARRY_EN
            assign lvl_cy[j+1] = lvl_en ? lvl_c : lvl_cy[j];
`else
            logic unused_lvl_c;
            assign unused_lvl_c = lvl_c;
`endif
        end

        assign sh_data[s] = lvl_d[REG_EVERY];
`ifdef SHIFTER_CARRY_EN
        assign sh_cy[s]   = lvl_cy[REG_EVERY];
`endif
    end

    // Stage boundary registers: flush clears valids, stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                vld_p[s]  <= 1'b0;
                data_p[s] <= '0;
                amt_p[s]  <= '0;
                mode_p[s] <= '0;
                tag_p[s]  <= '0;
                ill_p[s]  <= 1'b0;
`ifdef SHIFTER_CARRY_EN
                cy_p[s]   <= 1'b0;
`endif
            end
        end else if (flush) begin
            for (int s = 0; s < LAT; s++) begin
                vld_p[s] <= 1'b0;
            end
        end else if (!stall) begin
            for (int s = 0; s < LAT; s++) begin
                vld_p[s]  <= st_vld[s];
                data_p[s] <= sh_data[s];
                amt_p[s]  <= st_amt[s];
                mode_p[s] <= st_mode[s];
                tag_p[s]  <= st_tag[s];
                ill_p[s]  <= st_ill[s];
`ifdef SHIFTER_CARRY_EN
                cy_p[s]   <= sh_cy[s];
`endif
            end
        end
    end

    assign out_valid   = vld_p[LAT-1];
    assign out_data    = data_p[LAT-1];
    assign out_tag     = tag_p[LAT-1];
    assign out_illegal = ill_p[LAT-1];
`ifdef SHIFTER_CARRY_EN
    assign out_carry   = cy_p[LAT-1];
`endif

    // Amount bits already consumed by earlier stages, and the last stage's
    // amt/mode copies, are carried for uniformity but never read.
    logic unused_ctrl;
    always_comb begin
        unused_ctrl = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            unused_ctrl = unused_ctrl ^ (^amt_p[s]) ^ (^mode_p[s]) ^ (^st_amt[s]);
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: scoreboard bench for pipe_shifter. A 16-bit default
// instance and a 32-bit, one-level-per-stage instance are driven with
// directed vectors; expected results are pushed when an operation is
// accepted and popped by per-instance monitors when a result is consumed.
module tb_pipe_shifter;
    import shifter_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        ill;
        logic        cy;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  amt;
        logic [2:0]  mode;
        logic [31:0] exp;
        logic        ill;
        logic        cy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;

    // 16-bit instance
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_amt, in_tag, out_tag;
    logic [2:0]  in_mode;
    // 32-bit instance
    logic        rst2, flush2, in_valid2, in_ready2, out_valid2, out_ready2, out_illegal2;
    logic [31:0] in_data2, out_data2;
    logic [4:0]  in_amt2;
    logic [3:0]  in_tag2, out_tag2;
    logic [2:0]  in_mode2;
`ifdef SHIFTER_CARRY_EN
    logic out_carry, out_carry2;
`endif

    pipe_shifter u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_illegal(out_illegal)
`ifdef SHIFTER_CARRY_EN
        , .out_carry(out_carry)
`endif
    );

    pipe_shifter #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst2), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .in_amt(in_amt2), .in_mode(in_mode2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_tag(out_tag2), .out_illegal(out_illegal2)
`ifdef SHIFTER_CARRY_EN
        , .out_carry(out_carry2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per consumed result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL out16_unexpected: got result tag %0d, required no result", out_tag);
            end else begin
                m1 = q1.pop_front();
                check("out16_data", 32'(out_data), m1.data);
                check("out16_tag", 32'(out_tag), 32'(m1.tag));
                check("out16_illegal", 32'(out_illegal), 32'(m1.ill));
`ifdef SHIFTER_CARRY_EN
                check("out16_carry", 32'(out_carry), 32'(m1.cy));
`endif
                if (m1.due >= 0) check("out16_latency", 32'(cyc), 32'(m1.due));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL out32_unexpected: got result tag %0d, required no result", out_tag2);
            end else begin
                m2 = q2.pop_front();
                check("out32_data", out_data2, m2.data);
                check("out32_tag", 32'(out_tag2), 32'(m2.tag));
                check("out32_illegal", 32'(out_illegal2), 32'(m2.ill));
`ifdef SHIFTER_CARRY_EN
                check("out32_carry", 32'(out_carry2), 32'(m2.cy));
`endif
                if (m2.due >= 0) check("out32_latency", 32'(cyc), 32'(m2.due));
            end
        end
    end

    // Offer one operation and hold it until accepted (bounded).
    task automatic issue(input bit sel, input logic [31:0] d, input logic [4:0] amt,
                         input logic [2:0] mode, input logic [3:0] tag,
                         input logic [31:0] exp_d, input logic exp_ill, input logic exp_cy,
                         input bit keep, input bit lat);
        bit   ok;
        int   guard;
        exp_t e;
        ok = 1'b0;
        guard = 0;
        if (!sel) begin
            in_valid = 1'b1; in_data = d[15:0]; in_amt = amt[3:0]; in_mode = mode; in_tag = tag;
        end else begin
            in_valid2 = 1'b1; in_data2 = d; in_amt2 = amt; in_mode2 = mode; in_tag2 = tag;
        end
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = sel ? in_ready2 : in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready stayed 0, required 1 (tag %0d)", tag);
        end else if (keep) begin
            e.data = exp_d; e.tag = tag; e.ill = exp_ill; e.cy = exp_cy;
            e.due  = lat ? cyc + (sel ? 4 : 1) : -1;
            if (sel) q2.push_back(e);
            else     q1.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic drain(input bit sel);
        int guard;
        guard = 0;
        while ((sel ? q2.size() : q1.size()) != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check(sel ? "drain32_pending" : "drain16_pending", 32'(sel ? q2.size() : q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t v16 [12] = '{
        '{32'h8001,  5'd4, MODE_SRA, 32'hF800, 1'b0, 1'b0},
        '{32'h1234,  5'd4, MODE_ROR, 32'h4123, 1'b0, 1'b0},
        '{32'h1234,  5'd4, MODE_ROL, 32'h2341, 1'b0, 1'b1},
        '{32'h1234, 5'd15, MODE_SLL, 32'h0000, 1'b0, 1'b0},
        '{32'hABCD,  5'd3, 3'b111,   32'hABCD, 1'b1, 1'b0},
        '{32'h8001,  5'd1, MODE_SLL, 32'h0002, 1'b0, 1'b1},
        '{32'h0003,  5'd1, MODE_SRL, 32'h0001, 1'b0, 1'b1},
        '{32'h8000,  5'd1, MODE_ROL, 32'h0001, 1'b0, 1'b1},
        '{32'hBEEF,  5'd0, MODE_ROR, 32'hBEEF, 1'b0, 1'b0},
        '{32'h7FF0,  5'd4, MODE_SRA, 32'h07FF, 1'b0, 1'b0},
        '{32'hF000, 5'd15, MODE_SRA, 32'hFFFF, 1'b0, 1'b1},
        '{32'h1111,  5'd5, 3'b101,   32'h1111, 1'b1, 1'b0}
    };

    vec_t v32 [5] = '{
        '{32'h80000000, 5'd31, MODE_SRL, 32'h00000001, 1'b0, 1'b0},
        '{32'h12345678,  5'd8, MODE_ROR, 32'h78123456, 1'b0, 1'b0},
        '{32'h00000001, 5'd31, MODE_SLL, 32'h80000000, 1'b0, 1'b0},
        '{32'h80000000, 5'd31, MODE_SRA, 32'hFFFFFFFF, 1'b0, 1'b0},
        '{32'h80000001,  5'd1, MODE_ROL, 32'h00000003, 1'b0, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
        rst2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; in_amt2 = '0; in_mode2 = '0; in_tag2 = '0;
        out_ready = 1'b1; out_ready2 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst32_out_valid", 32'(out_valid2), 32'd0);
        check("rst32_out_data", out_data2, 32'd0);
`ifdef SHIFTER_CARRY_EN
        check("rst_out_carry", 32'(out_carry), 32'd0);
`endif
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst32_in_ready", 32'(in_ready2), 32'd1);
        @(posedge clk); #1;

        // Back-to-back directed vectors, full throughput.
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, v16[i].d, v16[i].amt, v16[i].mode, 4'(i), v16[i].exp, v16[i].ill, v16[i].cy, 1'b1, 1'b1);
        end
        idle();
        drain(1'b0);

        // Backpressure: fill the pipe, hold out_ready low for 5 cycles.
        out_ready = 1'b0;
        issue(1'b0, 32'h00FF, 5'd4, MODE_SLL, 4'd1, 32'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 32'h00FF, 5'd4, MODE_SRL, 4'd2, 32'h000F, 1'b0, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 16'h000F; in_amt = 4'd4; in_mode = MODE_ROR; in_tag = 4'd3;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'h0FF0);
            check("stall_out_tag", 32'(out_tag), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(1'b0, 32'h000F, 5'd4, MODE_ROR, 4'd3, 32'hF000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        drain(1'b0);

        // Flush with two ops in flight and a third offered.
        out_ready = 1'b0;
        issue(1'b0, 32'h0001, 5'd1, MODE_SLL, 4'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 32'h0002, 5'd1, MODE_SLL, 4'd9, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 16'h0004; in_amt = 4'd1; in_mode = MODE_SLL; in_tag = 4'd10;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_flush_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(1'b0, 32'h0100, 5'd8, MODE_SRL, 4'd11, 32'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        drain(1'b0);

        // 32-bit instance, five register stages.
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, v32[i].d, v32[i].amt, v32[i].mode, 4'(i + 4), v32[i].exp, v32[i].ill, v32[i].cy, 1'b1, 1'b1);
        end
        idle();
        drain(1'b1);

        // Asynchronous reset while results are pending.
        out_ready2 = 1'b0;
        issue(1'b1, 32'h0000FFFF, 5'd4, MODE_SLL, 4'd12, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 32'h0000FFFF, 5'd8, MODE_SLL, 4'd13, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        guard = 0;
        while (!out_valid2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst32_precond_valid", 32'(out_valid2), 32'd1);
        #2 rst2 = 1'b1;
        #1;
        check("async_rst32_out_valid", 32'(out_valid2), 32'd0);
        check("async_rst32_out_data", out_data2, 32'd0);
        check("async_rst32_out_tag", 32'(out_tag2), 32'd0);
        @(negedge clk);
        rst2 = 1'b0;
        out_ready2 = 1'b1;
        @(negedge clk);
        check("post_rst32_out_valid", 32'(out_valid2), 32'd0);
        check("post_rst32_in_ready2", 32'(in_ready2), 32'd1);
        check("final_q2_empty", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
